// File: rtl/microwave_timer_ctrl_pkg.sv
// Shared types, digit limits and BCD helpers for the microwave countdown controller.
package microwave_timer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COOKING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [3:0] MAX_MIN  = 4'd9;
  localparam logic [3:0] MAX_TENS = 4'd5;
  localparam logic [3:0] MAX_ONES = 4'd9;

  typedef struct packed {
    logic [3:0] mins;
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_time_t;

  function automatic logic bcd_is_zero(input bcd_time_t t);
    return (t.mins == 4'd0) && (t.tens == 4'd0) && (t.ones == 4'd0);
  endfunction

  // One-second decrement with borrow; saturates at 0:00.
  function automatic bcd_time_t bcd_dec(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (!bcd_is_zero(t)) begin
      if (t.ones != 4'd0) begin
        r.ones = t.ones - 4'd1;
      end else begin
        r.ones = MAX_ONES;
        if (t.tens != 4'd0) begin
          r.tens = t.tens - 4'd1;
        end else begin
          r.tens = MAX_TENS;
          r.mins = (t.mins != 4'd0) ? t.mins - 4'd1 : MAX_MIN;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/microwave_timer_ctrl_tick_gen.sv
// Seconds divider: pulses tick every TICK_DIV cycles while run is high.
module tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic restart,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = run && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/microwave_timer_ctrl.sv
// Microwave M:SS countdown: keypad entry, 1 Hz countdown, pause/door interlock, done alert.
module microwave_timer_ctrl
  import microwave_timer_ctrl_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int DONE_SECS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       door_closed,
  output logic [3:0] min,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       mag_on,
  output logic       done,
  output logic [1:0] state
);

  localparam int DW = (DONE_SECS > 1) ? $clog2(DONE_SECS + 1) : 1;
  localparam logic [DW-1:0] DONE_LAST = DW'(DONE_SECS - 1);

  state_t    state_q, state_d;
  bcd_time_t time_q, time_d;
  logic [DW-1:0] done_cnt_q, done_cnt_d;
  logic      mag_on_q, mag_on_d;
  logic      done_q, done_d;
  logic      tick, restart;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     ((state_q == ST_COOKING) || (state_q == ST_DONE)),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    state_d    = state_q;
    time_d     = time_q;
    done_cnt_d = done_cnt_q;
    if (clear) begin
      state_d = ST_IDLE;
      time_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && door_closed && !bcd_is_zero(time_q)) begin
            state_d = ST_COOKING;
          end else if (key_valid && (key_digit <= MAX_ONES) && (time_q.ones <= MAX_TENS)) begin
            time_d = '{mins: time_q.tens, tens: time_q.ones, ones: key_digit};
          end
        end
        ST_COOKING: begin
          if (!door_closed || stop) begin
            state_d = ST_PAUSED;
          end else if (tick) begin
            time_d = bcd_dec(time_q);
            if (bcd_is_zero(time_d)) begin
              state_d    = ST_DONE;
              done_cnt_d = '0;
            end
          end
        end
        ST_PAUSED: begin
          if (stop) begin
            state_d = ST_IDLE;
            time_d  = '0;
          end else if (start && door_closed) begin
            state_d = ST_COOKING;
          end
        end
        default: begin
          if (start || stop) begin
            state_d = ST_IDLE;
          end else if (tick) begin
            if (done_cnt_q == DONE_LAST) begin
              state_d = ST_IDLE;
            end else begin
              done_cnt_d = done_cnt_q + 1'b1;
            end
          end
        end
      endcase
    end
    mag_on_d = (state_d == ST_COOKING);
    done_d   = (state_d == ST_DONE);
  end

  // Every fresh entry to a running state starts a full second.
  assign restart = (state_d != state_q) &&
                   ((state_d == ST_COOKING) || (state_d == ST_DONE));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      time_q     <= '0;
      done_cnt_q <= '0;
      mag_on_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      time_q     <= time_d;
      done_cnt_q <= done_cnt_d;
      mag_on_q   <= mag_on_d;
      done_q     <= done_d;
    end
  end

  assign min      = time_q.mins;
  assign sec_tens = time_q.tens;
  assign sec_ones = time_q.ones;
  assign mag_on   = mag_on_q;
  assign done     = done_q;
  assign state    = state_q;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Directed self-checking bench for microwave_timer_ctrl with TICK_DIV=4, DONE_SECS=3.
module tb_microwave_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic       door_closed = 1'b1;
  logic [3:0] min, sec_tens, sec_ones;
  logic       mag_on, done;
  logic [1:0] state;

  int tests = 0;
  int fails = 0;

  microwave_timer_ctrl #(.TICK_DIV(4), .DONE_SECS(3)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_digit(key_digit),
    .start(start), .stop(stop), .clear(clear), .door_closed(door_closed),
    .min(min), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .mag_on(mag_on), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    key_valid = 1'b1; key_digit = d;
    step(1);
    key_valid = 1'b0; key_digit = 4'd0;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(1); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; step(1); stop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; step(1); clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(2);
    tests++;
    if ({state, min, sec_tens, sec_ones, mag_on, done} !== 16'h0) begin
      $display("FAIL reset_state got st=%0d %0d:%0d%0d mag=%0b done=%0b want all 0",
               state, min, sec_tens, sec_ones, mag_on, done);
      fails++;
    end
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_digit_entry();
    press(4'd1); press(4'd3); press(4'd0);
    tests++;
    if ({min, sec_tens, sec_ones} !== 12'h130) begin
      $display("FAIL entry_130 got %h want 130", {min, sec_tens, sec_ones}); fails++;
    end
    press(4'd5);
    tests++;
    if ({min, sec_tens, sec_ones} !== 12'h305) begin
      $display("FAIL entry_305 got %h want 305", {min, sec_tens, sec_ones}); fails++;
    end
    press(4'd12);
    tests++;
    if ({min, sec_tens, sec_ones} !== 12'h305) begin
      $display("FAIL entry_bad_digit got %h want 305", {min, sec_tens, sec_ones}); fails++;
    end
    press(4'd7);
    press(4'd1);
    tests++;
    if ({min, sec_tens, sec_ones} !== 12'h057) begin
      $display("FAIL entry_illegal_tens got %h want 057", {min, sec_tens, sec_ones}); fails++;
    end
    pulse_clear();
  endtask

  task automatic test_countdown();
    press(4'd1); press(4'd0); press(4'd0);
    pulse_start();
    tests++;
    if (mag_on !== 1'b1 || state !== 2'd1) begin
      $display("FAIL cd_start got mag=%0b st=%0d want 1/1", mag_on, state); fails++;
    end
    step(4);
    tests++;
    if ({min, sec_tens, sec_ones} !== 12'h059) begin
      $display("FAIL cd_first_tick got %h want 059", {min, sec_tens, sec_ones}); fails++;
    end
    step(59 * 4);
    tests++;
    if ({state, min, sec_tens, sec_ones, mag_on, done} !== {2'd3, 12'h000, 1'b0, 1'b1}) begin
      $display("FAIL cd_done got st=%0d %h mag=%0b done=%0b want 3 000 0 1",
               state, {min, sec_tens, sec_ones}, mag_on, done); fails++;
    end
    step(11);
    tests++;
    if (done !== 1'b1 || state !== 2'd3) begin
      $display("FAIL cd_done_hold got done=%0b st=%0d want 1/3", done, state); fails++;
    end
    step(1);
    tests++;
    if (done !== 1'b0 || state !== 2'd0) begin
      $display("FAIL cd_done_exit got done=%0b st=%0d want 0/0", done, state); fails++;
    end
  endtask

  task automatic test_borrow();
    int t;
    logic [11:0] exp;
    press(4'd2); press(4'd1); press(4'd0);
    pulse_start();
    t = 130;
    for (int i = 0; i < 11; i++) begin
      step(4);
      t--;
      exp = {4'(t / 60), 4'((t % 60) / 10), 4'(t % 10)};
      tests++;
      if ({min, sec_tens, sec_ones} !== exp || sec_tens > 4'd5) begin
        $display("FAIL borrow_%0d got %h want %h", i, {min, sec_tens, sec_ones}, exp); fails++;
      end
    end
    pulse_clear();
  endtask

  task automatic test_door();
    press(4'd4); press(4'd5);
    pulse_start();
    step(3);
    door_closed = 1'b0;
    step(1);
    tests++;
    if ({state, min, sec_tens, sec_ones, mag_on} !== {2'd2, 12'h045, 1'b0}) begin
      $display("FAIL door_pause got st=%0d %h mag=%0b want 2 045 0",
               state, {min, sec_tens, sec_ones}, mag_on); fails++;
    end
    pulse_start();
    press(4'd7);
    tests++;
    if (state !== 2'd2 || {min, sec_tens, sec_ones} !== 12'h045) begin
      $display("FAIL door_open_start got st=%0d %h want 2 045", state, {min, sec_tens, sec_ones});
      fails++;
    end
    door_closed = 1'b1;
    pulse_start();
    tests++;
    if (state !== 2'd1 || mag_on !== 1'b1) begin
      $display("FAIL door_resume got st=%0d mag=%0b want 1/1", state, mag_on); fails++;
    end
    step(3);
    tests++;
    if ({min, sec_tens, sec_ones} !== 12'h045) begin
      $display("FAIL door_full_second_early got %h want 045", {min, sec_tens, sec_ones}); fails++;
    end
    step(1);
    tests++;
    if ({min, sec_tens, sec_ones} !== 12'h044) begin
      $display("FAIL door_full_second got %h want 044", {min, sec_tens, sec_ones}); fails++;
    end
    pulse_clear();
  endtask

  task automatic test_stop_clear();
    press(4'd2); press(4'd0);
    pulse_start();
    step(1);
    pulse_stop();
    tests++;
    if (state !== 2'd2 || {min, sec_tens, sec_ones} !== 12'h020 || mag_on !== 1'b0) begin
      $display("FAIL stop_pause got st=%0d %h mag=%0b want 2 020 0",
               state, {min, sec_tens, sec_ones}, mag_on); fails++;
    end
    pulse_stop();
    tests++;
    if (state !== 2'd0 || {min, sec_tens, sec_ones} !== 12'h000) begin
      $display("FAIL stop_idle got st=%0d %h want 0 000", state, {min, sec_tens, sec_ones}); fails++;
    end
    press(4'd9);
    pulse_start();
    pulse_stop();
    start = 1'b1; stop = 1'b1; step(1); start = 1'b0; stop = 1'b0;
    tests++;
    if (state !== 2'd0 || {min, sec_tens, sec_ones} !== 12'h000) begin
      $display("FAIL stop_start_paused got st=%0d %h want 0 000",
               state, {min, sec_tens, sec_ones}); fails++;
    end
    press(4'd1);
    pulse_start();
    step(4);
    pulse_clear();
    tests++;
    if (state !== 2'd0 || done !== 1'b0) begin
      $display("FAIL clear_done got st=%0d done=%0b want 0/0", state, done); fails++;
    end
    pulse_start();
    tests++;
    if (state !== 2'd0 || mag_on !== 1'b0) begin
      $display("FAIL start_zero got st=%0d mag=%0b want 0/0", state, mag_on); fails++;
    end
  endtask

  task automatic test_reset_mid_cook();
    press(4'd3); press(4'd3);
    pulse_start();
    step(1);
    rst_n = 1'b0; start = 1'b1;
    step(1);
    tests++;
    if ({state, min, sec_tens, sec_ones, mag_on, done} !== 16'h0) begin
      $display("FAIL reset_mid_cook got st=%0d %h mag=%0b done=%0b want all 0",
               state, {min, sec_tens, sec_ones}, mag_on, done); fails++;
    end
    rst_n = 1'b1; start = 1'b0;
    step(1);
    tests++;
    if (state !== 2'd0 || mag_on !== 1'b0) begin
      $display("FAIL reset_start_ignored got st=%0d mag=%0b want 0/0", state, mag_on); fails++;
    end
  endtask

  initial begin
    test_reset();
    test_digit_entry();
    test_countdown();
    test_borrow();
    test_door();
    test_stop_clear();
    test_reset_mid_cook();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
